// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared widths, defaults and state encoding for the data-memory arbiter
package dm_arb_pkg;

    localparam int ADDR_W           = 9;
    localparam int DATA_W           = 16;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    // Width able to hold 0..limit, never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dm_arb_wait_counter.sv
// rtl/dm_arb_wait_counter.sv - saturating count of cycles an IO request has been denied
module dm_arb_wait_counter
    import dm_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF,
    parameter int CW    = cnt_width(LIMIT)
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          at_limit
);

    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt >= LIM);

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - single-port data-memory arbiter between the core and the IO requester
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ack,
    output logic [DATA_W-1:0] io_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_rdata
);

    localparam int CW = cnt_width(STARVE_LIMIT);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          at_limit;
    logic          io_grant;
    logic          core_grant;
    logic          cnt_inc;

    // Grants are masked during reset so no memory write can slip through.
    assign io_grant   = !rst && io_req && (state != ACK) && (!core_req || at_limit);
    assign core_grant = !rst && core_req && !io_grant;
    assign core_stall = core_req && io_grant;
    assign core_rdata = dm_rdata;
    assign io_ack     = (state == ACK);
    assign cnt_inc    = io_req && !io_grant && (state != ACK);

    dm_arb_wait_counter #(
        .LIMIT (STARVE_LIMIT),
        .CW    (CW)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (!cnt_inc),
        .inc      (cnt_inc),
        .cnt      (wait_cnt),
        .at_limit (at_limit)
    );

    always_comb begin
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        if (io_grant) begin
            dm_we    = io_we;
            dm_addr  = io_addr;
            dm_wdata = io_wdata;
        end else if (core_grant) begin
            dm_we    = core_we;
            dm_addr  = core_addr;
            dm_wdata = core_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_rdata <= '0;
        end else if (io_grant && !io_we) begin
            io_rdata <= dm_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ACK always returns to IDLE so a held request is re-evaluated as a fresh one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (io_grant) begin
                    state_nxt = ACK;
                end else if (io_req) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (io_grant) begin
                    state_nxt = ACK;
                end else if (!io_req) begin
                    state_nxt = IDLE;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter with a cycle-level reference model
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req, core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;
    logic              io_req, io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              io_ack;
    logic [DATA_W-1:0] io_rdata;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_we;
    logic [DATA_W-1:0] dm_rdata;

    logic [DATA_W-1:0] mem  [0:511];
    logic [DATA_W-1:0] mmem [0:511];

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    int          m_wait;
    bit          m_ack;
    logic [15:0] m_rdata;

    always #5 clk = ~clk;

    dm_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .io_req     (io_req),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_ack     (io_ack),
        .io_rdata   (io_rdata),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_we      (dm_we),
        .dm_rdata   (dm_rdata)
    );

    assign dm_rdata = mem[dm_addr];
    always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: IO wins when the port is free or it has waited LIMIT cycles, never in its ack cycle.
    always @(negedge clk) begin
        bit          g, cg, e_we;
        logic [8:0]  e_addr;
        logic [15:0] e_wd;
        if (cmp_on) begin
            if (rst) begin
                chk("rst_dm_we", dm_we, 0);
                chk("rst_core_stall", core_stall, 0);
                chk("rst_io_ack", io_ack, 0);
                chk("rst_io_rdata", io_rdata, 0);
                m_wait  = 0;
                m_ack   = 1'b0;
                m_rdata = '0;
            end else begin
                g  = io_req && !m_ack && (!core_req || m_wait >= LIMIT);
                cg = core_req && !g;
                e_we = 1'b0; e_addr = '0; e_wd = '0;
                if (g) begin
                    e_we = io_we; e_addr = io_addr; e_wd = io_wdata;
                end else if (cg) begin
                    e_we = core_we; e_addr = core_addr; e_wd = core_wdata;
                end
                chk("model_dm_we", dm_we, e_we);
                chk("model_dm_addr", dm_addr, e_addr);
                chk("model_dm_wdata", dm_wdata, e_wd);
                chk("model_core_stall", core_stall, core_req && g);
                chk("model_io_ack", io_ack, m_ack);
                chk("model_io_rdata", io_rdata, m_rdata);
                if (cg && !core_we) chk("model_core_rdata", core_rdata, mmem[core_addr]);
                if (g && !io_we) m_rdata = mmem[io_addr];
                if (e_we) mmem[e_addr] = e_wd;
                m_wait = (g || !io_req || m_ack) ? 0 : ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1);
                m_ack  = g;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic r, input logic w, input logic [8:0] a, input logic [15:0] d);
        core_req = r; core_we = w; core_addr = a; core_wdata = d;
    endtask

    task automatic set_io(input logic r, input logic w, input logic [8:0] a, input logic [15:0] d);
        io_req = r; io_we = w; io_addr = a; io_wdata = d;
    endtask

    initial begin
        logic [7:0] pat;
        bit         got;
        for (int i = 0; i < 512; i++) begin
            mem[i]  = 16'(i * 7 + 3);
            mmem[i] = 16'(i * 7 + 3);
        end
        m_wait = 0; m_ack = 1'b0; m_rdata = '0;
        rst = 1'b1;
        set_core(1'b1, 1'b1, 9'h005, 16'hFFFF);
        set_io(1'b0, 1'b0, 9'h000, 16'h0000);
        cmp_on = 1'b1;

        // Reset with a core write asserted
        @(negedge clk);
        chk("reset_dm_we_forced", dm_we, 0);
        chk("reset_io_ack", io_ack, 0);
        chk("reset_io_rdata", io_rdata, 0);
        step();
        step();
        rst = 1'b0;
        set_core(1'b0, 1'b0, 9'h000, 16'h0000);

        // Core only write then read-back
        step();
        set_core(1'b1, 1'b1, 9'h005, 16'h1234);
        @(negedge clk);
        chk("core_wr_dm_we", dm_we, 1);
        chk("core_wr_stall", core_stall, 0);
        chk("core_wr_addr", dm_addr, 9'h005);
        step();
        set_core(1'b1, 1'b0, 9'h005, 16'h0000);
        @(negedge clk);
        chk("core_rd_data", core_rdata, 16'h1234);
        step();
        set_core(1'b1, 1'b1, 9'h010, 16'h00AA);

        // IO only read
        step();
        set_core(1'b0, 1'b0, 9'h000, 16'h0000);
        set_io(1'b1, 1'b0, 9'h010, 16'h0000);
        @(negedge clk);
        chk("io_rd_grant_addr", dm_addr, 9'h010);
        chk("io_rd_c0_ack", io_ack, 0);
        step();
        @(negedge clk);
        chk("io_rd_c1_ack", io_ack, 1);
        chk("io_rd_c1_data", io_rdata, 16'h00AA);
        chk("io_rd_c1_dm_we", dm_we, 0);
        step();
        io_req = 1'b0;
        @(negedge clk);
        chk("io_rd_c2_ack", io_ack, 0);
        chk("io_rd_c2_held", io_rdata, 16'h00AA);

        // Starvation bound with the core requesting every cycle
        step();
        set_core(1'b1, 1'b0, 9'h005, 16'h0000);
        set_io(1'b1, 1'b0, 9'h010, 16'h0000);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("starve_c%0d_stall", c), core_stall, (c == 4));
            chk($sformatf("starve_c%0d_ack", c), io_ack, (c == 5));
            chk($sformatf("starve_c%0d_addr", c), dm_addr, (c == 4) ? 9'h010 : 9'h005);
            step();
            if (c == 5) io_req = 1'b0;
        end
        core_req = 1'b0;

        // Same-cycle writes: core first, IO overwrites later
        set_core(1'b1, 1'b1, 9'h020, 16'h1111);
        set_io(1'b1, 1'b1, 9'h020, 16'h2222);
        @(negedge clk);
        chk("same_c0_wdata", dm_wdata, 16'h1111);
        chk("same_c0_stall", core_stall, 0);
        step();
        core_req = 1'b0;
        @(negedge clk);
        chk("same_c1_mem", mem[9'h020], 16'h1111);
        chk("same_c1_wdata", dm_wdata, 16'h2222);
        step();
        @(negedge clk);
        chk("same_c2_ack", io_ack, 1);
        chk("same_c2_mem", mem[9'h020], 16'h2222);
        step();
        io_req = 1'b0;

        // Reset in the middle of a wait
        set_core(1'b1, 1'b0, 9'h005, 16'h0000);
        set_io(1'b1, 1'b0, 9'h010, 16'h0000);
        step();
        step();
        @(negedge clk);
        chk("midwait_cnt", dut.wait_cnt, 2);
        #1;
        rst = 1'b1;
        set_core(1'b1, 1'b1, 9'h030, 16'h5555);
        @(negedge clk);
        chk("midwait_rst_dm_we", dm_we, 0);
        chk("midwait_rst_state", int'(dut.state), int'(IDLE));
        chk("midwait_rst_cnt", dut.wait_cnt, 0);
        chk("midwait_rst_ack", io_ack, 0);
        step();
        @(negedge clk);
        chk("midwait_rst2_ack", io_ack, 0);
        step();
        rst = 1'b0;
        set_core(1'b0, 1'b0, 9'h000, 16'h0000);
        io_req = 1'b0;
        @(negedge clk);
        chk("midwait_post_ack", io_ack, 0);
        chk("midwait_no_write", mem[9'h030], 16'h0153);

        // Held IO request gives two separate writes
        step();
        set_io(1'b1, 1'b1, 9'h040, 16'hBEEF);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_c%0d_ack", c), io_ack, (c == 1 || c == 3));
            chk($sformatf("b2b_c%0d_dm_we", c), dm_we, (c == 0 || c == 2));
            step();
            if (c == 1) io_wdata = 16'hCAFE;
            if (c == 3) io_req = 1'b0;
        end
        @(negedge clk);
        chk("b2b_mem", mem[9'h040], 16'hCAFE);

        // Mixed core traffic while an IO read waits
        step();
        set_io(1'b1, 1'b0, 9'h005, 16'h0000);
        pat = 8'b1101_0111;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            set_core(pat[c % 8], 1'(c), 9'(9'h100 + c), 16'(c * 16'h0111));
            @(negedge clk);
            if (io_ack) got = 1'b1;
            step();
            if (got) io_req = 1'b0;
        end
        chk("mixed_ack_seen", got, 1);
        set_core(1'b0, 1'b0, 9'h000, 16'h0000);
        io_req = 1'b0;
        step();
        step();
        @(negedge clk);
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive cycles an IO request waits while the core holds the memory port.
REQ-002 CLK  in  1  system clock, all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 CORE_REQ  in  1  core data-memory access this cycle (LOAD|STORE|PUSH|POP).
REQ-005 CORE_WE  in  1  core access is a write.
REQ-006 CORE_ADDR  in  9  core word address.
REQ-007 CORE_WDATA  in  16  core write data.
REQ-008 CORE_RDATA  out  16  read data to core, combinational from DM_RDATA.
REQ-009 CORE_STALL  out  1  core access not served this cycle; core holds PC and its request.
REQ-010 IO_REQ  in  1  keypad/display requester access; held with IO_WE, IO_ADDR and IO_WDATA stable until IO_ACK.
REQ-011 IO_WE  in  1  IO access is a write.
REQ-012 IO_ADDR  in  9  IO word address.
REQ-013 IO_WDATA  in  16  IO write data.
REQ-014 IO_ACK  out  1  one-cycle pulse, IO access completed.
REQ-015 IO_RDATA  out  16  registered IO read data, valid while IO_ACK=1, held afterwards.
REQ-016 DM_ADDR  out  9; DM_WDATA  out  16; DM_WE  out  1; DM_RDATA  in  16  single-port DataMemory (synchronous write, combinational read).

Function
REQ-017 Port-owner selection and the DM_* mux are combinational within the cycle; core reads and writes have zero added latency when granted.
REQ-018 FSM states: IDLE (no IO pending), WAIT (IO pending, not yet granted), ACK (IO served last cycle).
REQ-019 io_grant = IO_REQ & state!=ACK & (!CORE_REQ | wait_cnt>=STARVE_LIMIT).
REQ-020 core_grant = CORE_REQ & !io_grant; CORE_STALL = CORE_REQ & io_grant.
REQ-021 When nothing is granted: DM_WE=0, DM_ADDR=0, DM_WDATA=0.
REQ-022 IDLE: io_grant -> ACK; IO_REQ & !io_grant -> WAIT with wait_cnt=1; else stay, wait_cnt=0.
REQ-023 WAIT: io_grant -> ACK, wait_cnt=0; else wait_cnt increments, saturating at STARVE_LIMIT; IO_REQ dropped (protocol error) -> IDLE, wait_cnt=0.
REQ-024 ACK: IO_ACK=1 for exactly this cycle; IO not eligible (prevents double-serving the held request); next state IDLE.
REQ-025 On an io_grant cycle IO_RDATA captures DM_RDATA (reads); for writes IO_RDATA is unchanged.
REQ-026 Latency: IO_ACK rises exactly one cycle after the io_grant cycle; worst case, with the core requesting every cycle, IO_ACK comes STARVE_LIMIT+1 cycles after IO_REQ rises.
REQ-027 Same-cycle contention below the limit: core wins; the IO write occurs later and therefore overwrites the core write at the same address.
REQ-028 Back-to-back IO: an IO_REQ held high after IO_ACK is a new request, evaluated from IDLE on the cycle after ACK.

Reset
REQ-029 While RST=1: state=IDLE, wait_cnt=0, IO_ACK=0, IO_RDATA=0, DM_WE=0 (forced even if CORE_REQ&CORE_WE), CORE_STALL=0.
REQ-030 Reset mid-WAIT or mid-ACK abandons the IO transaction with no IO_ACK; the requester re-issues after RST falls.

Structure
REQ-031 Shared package dm_arb_pkg holds ADDR_W=9, DATA_W=16, STARVE_LIMIT_DEF=4, and the state encoding IDLE/WAIT/ACK.
REQ-032 One sub-module dm_arb_wait_counter (saturating counter: clear, increment, >=limit flag); all remaining logic stays in dm_arbiter.

Verification
REQ-033 Core only: CORE_REQ=1, CORE_WE=1, addr 0x005, data 0x1234 -> DM_WE=1 same cycle, CORE_STALL=0; next cycle, a core read of 0x005 -> CORE_RDATA=0x1234.
REQ-034 IO only: memory[0x010]=0x00AA, IO read 0x010 -> granted in cycle 0, IO_ACK=1 in cycle 1 only, IO_RDATA=0x00AA.
REQ-035 Starvation: CORE_REQ=1 every cycle, IO_REQ rises at cycle 0 -> io_grant and CORE_STALL=1 at cycle 4 only, IO_ACK at cycle 5, core served again at cycle 5.
REQ-036 Same-cycle write to 0x020: core writes 0x1111, IO writes 0x2222 -> memory=0x1111 after that cycle, memory=0x2222 once IO_ACK has pulsed.
REQ-037 Reset mid-WAIT: wait_cnt=2, RST pulse -> state=IDLE, wait_cnt=0, no IO_ACK, DM_WE=0 during reset even with a core write asserted.
REQ-038 Held IO_REQ for two writes -> two distinct IO_ACK pulses separated by at least one cycle, with no extra DM_WE from the ACK cycle.
